instr_encoder: RTL and testbench

Streaming MIPS instruction encoder. It is the inverse of the control decoder: it takes mnemonic-level requests (op, rs, rt, rd, imm, target) and emits 32-bit instruction words. Each word is written into instruction memory at an auto-incrementing word address. Used by the test/boot loader to build programs for the single-cycle CPU.

---
 rtl/isa_pkg.sv | 75 +++++++
 rtl/instr_pack.sv | 53 +++++
 rtl/instr_encoder.sv | 179 +++++++++++++++++
 tb/tb_instr_encoder.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/isa_pkg.sv
// Shared MIPS ISA definitions: mnemonic codes, opcode/funct values, field
// positions, and small word-assembly helpers used by the encoder (and by the
// control decoder that consumes these words).
package isa_pkg;

    // Mnemonic codes presented on the encoder request port
    typedef enum logic [4:0] {
        MN_ADD  = 5'd0,
        MN_SUB  = 5'd1,
        MN_AND  = 5'd2,
        MN_OR   = 5'd3,
        MN_SLT  = 5'd4,
        MN_SRL  = 5'd5,
        MN_XOR  = 5'd6,
        MN_LW   = 5'd7,
        MN_SW   = 5'd8,
        MN_BEQ  = 5'd9,
        MN_BNE  = 5'd10,
        MN_J    = 5'd11,
        MN_ADDI = 5'd12,
        MN_ANDI = 5'd13,
        MN_ORI  = 5'd14,
        MN_SLTI = 5'd15,
        MN_XORI = 5'd16,
        MN_LUI  = 5'd17,
        MN_LI   = 5'd18
    } mnem_e;

    // Primary opcodes
    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_J     = 6'h02;
    localparam logic [5:0] OPC_BEQ   = 6'h04;
    localparam logic [5:0] OPC_BNE   = 6'h05;
    localparam logic [5:0] OPC_ADDI  = 6'h08;
    localparam logic [5:0] OPC_SLTI  = 6'h0A;
    localparam logic [5:0] OPC_ANDI  = 6'h0C;
    localparam logic [5:0] OPC_ORI   = 6'h0D;
    localparam logic [5:0] OPC_XORI  = 6'h0E;
    localparam logic [5:0] OPC_LUI   = 6'h0F;
    localparam logic [5:0] OPC_LW    = 6'h23;
    localparam logic [5:0] OPC_SW    = 6'h2B;

    // R-type function codes
    localparam logic [5:0] FUNCT_SRL = 6'h02;
    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_AND = 6'h24;
    localparam logic [5:0] FUNCT_OR  = 6'h25;
    localparam logic [5:0] FUNCT_XOR = 6'h26;
    localparam logic [5:0] FUNCT_SLT = 6'h2A;

    // Least-significant bit of each instruction field
    localparam int OP_LSB    = 26;
    localparam int RS_LSB    = 21;
    localparam int RT_LSB    = 16;
    localparam int RD_LSB    = 11;
    localparam int SHAMT_LSB = 6;

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] shamt,
                                          input logic [5:0] funct);
        enc_r = (32'(OPC_RTYPE) << OP_LSB) | (32'(rs) << RS_LSB) | (32'(rt) << RT_LSB) |
                (32'(rd) << RD_LSB) | (32'(shamt) << SHAMT_LSB) | 32'(funct);
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] opc, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        enc_i = (32'(opc) << OP_LSB) | (32'(rs) << RS_LSB) | (32'(rt) << RT_LSB) | 32'(imm);
    endfunction

    function automatic logic [31:0] enc_j(input logic [25:0] target);
        enc_j = (32'(OPC_J) << OP_LSB) | 32'(target);
    endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational mnemonic-to-word packer. For LI it returns the leading LUI
// half and raises is_li; the caller builds the trailing ORI.
// Build option: LI_PSEUDO_EN makes LI legal; otherwise it is flagged illegal.
module instr_pack
    import isa_pkg::*;
(
    input  logic [4:0]  op,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [31:0] imm,
    input  logic [25:0] target,
    output logic [31:0] word,
    output logic        illegal,
    output logic        is_li
);

    // Select the field layout for the requested mnemonic
    always_comb begin
        word    = '0;
        illegal = 1'b0;
        is_li   = 1'b0;
        case (mnem_e'(op))
            MN_ADD:  word = enc_r(rs, rt, rd, 5'd0, FUNCT_ADD);
            MN_SUB:  word = enc_r(rs, rt, rd, 5'd0, FUNCT_SUB);
            MN_AND:  word = enc_r(rs, rt, rd, 5'd0, FUNCT_AND);
            MN_OR:   word = enc_r(rs, rt, rd, 5'd0, FUNCT_OR);
            MN_SLT:  word = enc_r(rs, rt, rd, 5'd0, FUNCT_SLT);
            MN_XOR:  word = enc_r(rs, rt, rd, 5'd0, FUNCT_XOR);
            MN_SRL:  word = enc_r(5'd0, rt, rd, imm[4:0], FUNCT_SRL);
            MN_LW:   word = enc_i(OPC_LW, rs, rt, imm[15:0]);
            MN_SW:   word = enc_i(OPC_SW, rs, rt, imm[15:0]);
            MN_BEQ:  word = enc_i(OPC_BEQ, rs, rt, imm[15:0]);
            MN_BNE:  word = enc_i(OPC_BNE, rs, rt, imm[15:0]);
            MN_ADDI: word = enc_i(OPC_ADDI, rs, rt, imm[15:0]);
            MN_ANDI: word = enc_i(OPC_ANDI, rs, rt, imm[15:0]);
            MN_ORI:  word = enc_i(OPC_ORI, rs, rt, imm[15:0]);
            MN_SLTI: word = enc_i(OPC_SLTI, rs, rt, imm[15:0]);
            MN_XORI: word = enc_i(OPC_XORI, rs, rt, imm[15:0]);
            MN_LUI:  word = enc_i(OPC_LUI, 5'd0, rt, imm[15:0]);
            MN_J:    word = enc_j(target);
            MN_LI: begin
                word  = enc_i(OPC_LUI, 5'd0, rt, imm[31:16]);
                is_li = 1'b1;
`ifndef LI_PSEUDO_EN
                illegal = 1'b1;
`endif
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Streaming MIPS instruction encoder: accepts mnemonic requests and writes
// one encoded word per cycle into instruction memory at an auto-incrementing
// address, stopping (never wrapping) when the memory is full.
// Build option: LI_PSEUDO_EN enables the two-word LI pseudo-instruction
// (LUI + ORI) and the LI2 state; without it LI is treated as illegal.
module instr_encoder
    import isa_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_op,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [31:0]       in_imm,
    input  logic [25:0]       in_target,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   word_count,
    output logic              full,
    output logic              err_illegal
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

`ifdef LI_PSEUDO_EN
    typedef enum logic {ST_RUN = 1'b0, ST_LI2 = 1'b1} state_e;
`else
    typedef enum logic {ST_RUN = 1'b0} state_e;
`endif

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic                full_q, full_d;
    logic                err_q, err_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
`ifdef LI_PSEUDO_EN
    logic [4:0]          li_rt_q, li_rt_d;
    logic [15:0]         li_lo_q, li_lo_d;
`endif

    logic [31:0] pk_word;
    logic        pk_illegal;
    logic        pk_is_li;
    logic        hs;
    logic        write;
    logic [31:0] wr_word;

    instr_pack u_pack (
        .op      (in_op),
        .rs      (in_rs),
        .rt      (in_rt),
        .rd      (in_rd),
        .imm     (in_imm),
        .target  (in_target),
        .word    (pk_word),
        .illegal (pk_illegal),
        .is_li   (pk_is_li)
    );

    assign in_ready = !start && !full_q && (state_q == ST_RUN);
    assign hs       = in_valid && in_ready;

    // Next-state: start/abort, LI second half, request consumption, pointer advance
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        full_d  = full_q;
        err_d   = err_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        write   = 1'b0;
        wr_word = '0;
`ifdef LI_PSEUDO_EN
        li_rt_d = li_rt_q;
        li_lo_d = li_lo_q;
`endif
        if (start) begin
            state_d = ST_RUN;
            ptr_d   = '0;
            count_d = '0;
            full_d  = 1'b0;
            err_d   = 1'b0;
        end
`ifdef LI_PSEUDO_EN
        else if (state_q == ST_LI2) begin
            write   = 1'b1;
            wr_word = enc_i(OPC_ORI, li_rt_q, li_rt_q, li_lo_q);
            state_d = ST_RUN;
        end
`endif
        else if (hs) begin
`ifdef LI_PSEUDO_EN
            // LI needs two free slots; with only the last one left it is rejected
            if (pk_illegal || (pk_is_li && ptr_q == LAST_ADDR)) begin
                err_d = 1'b1;
            end else begin
                write   = 1'b1;
                wr_word = pk_word;
                if (pk_is_li) begin
                    state_d = ST_LI2;
                    li_rt_d = in_rt;
                    li_lo_d = in_imm[15:0];
                end
            end
`else
            if (pk_illegal || pk_is_li) begin
                err_d = 1'b1;
            end else begin
                write   = 1'b1;
                wr_word = pk_word;
            end
`endif
        end

        // The pointer parks on the last address once it has been written
        if (write) begin
            we_d    = 1'b1;
            addr_d  = ptr_q;
            wdata_d = wr_word;
            count_d = count_q + (ADDR_W+1)'(1);
            if (ptr_q == LAST_ADDR) begin
                full_d = 1'b1;
            end else begin
                ptr_d = ptr_q + ADDR_W'(1);
            end
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            ptr_q   <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
`ifdef LI_PSEUDO_EN
            li_rt_q <= '0;
            li_lo_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
            full_q  <= full_d;
            err_q   <= err_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
`ifdef LI_PSEUDO_EN
            li_rt_q <= li_rt_d;
            li_lo_q <= li_lo_d;
`endif
        end
    end

    assign imem_we     = we_q;
    assign imem_addr   = addr_q;
    assign imem_wdata  = wdata_q;
    assign word_count  = count_q;
    assign full        = full_q;
    assign err_illegal = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder with a 4-word memory. A behavioural
// model queues expected memory writes; a negedge monitor pops and compares.
// Honours LI_PSEUDO_EN the same way as the design.
module tb_instr_encoder;

    localparam int AW    = 2;
    localparam int DEPTH = 2 ** AW;
`ifdef LI_PSEUDO_EN
    localparam bit LI_EN = 1'b1;
`else
    localparam bit LI_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [4:0]    in_op = '0, in_rs = '0, in_rt = '0, in_rd = '0;
    logic [31:0]   in_imm = '0;
    logic [25:0]   in_target = '0;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic [AW:0]   word_count;
    logic          full;
    logic          err_illegal;

    instr_encoder #(.ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .start(start),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .in_imm(in_imm), .in_target(in_target),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .word_count(word_count), .full(full), .err_illegal(err_illegal)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    bit mon_en = 1'b0;

    typedef struct { int addr; logic [31:0] data; } wr_t;
    wr_t exp_q[$];

    // Reference model state
    int          m_ptr = 0, m_count = 0;
    bit          m_full = 0, m_err = 0, m_li_pend = 0, m_fresh = 1, m_hs = 0;
    int          m_li_rt = 0;
    longint      m_li_lo = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Spec-level encoder: plain arithmetic on field values
    function automatic void model_enc(input int op, input int rs, input int rt, input int rd,
                                      input longint imm, input longint tgt,
                                      output logic [31:0] w, output bit legal, output bit li);
        int funct[7] = '{'h20, 'h22, 'h24, 'h25, 'h2A, 'h02, 'h26};
        int opc[18]  = '{0, 0, 0, 0, 0, 0, 0, 'h23, 'h2B, 'h04, 'h05, 'h02,
                         'h08, 'h0C, 'h0D, 'h0A, 'h0E, 'h0F};
        longint v = 0;
        legal = 1; li = 0;
        if (op <= 6) begin
            if (op == 5) v = rt * 2**16 + rd * 2**11 + (imm % 32) * 64 + funct[op];
            else         v = rs * 2**21 + rt * 2**16 + rd * 2**11 + funct[op];
        end else if (op == 11) begin
            v = 2 * 2**26 + tgt;
        end else if (op <= 17) begin
            v = longint'(opc[op]) * 2**26 + (op == 17 ? 0 : rs) * 2**21 + rt * 2**16 + imm % 65536;
        end else if (op == 18) begin
            li = 1;
            v  = longint'('h0F) * 2**26 + rt * 2**16 + imm / 65536;
        end else begin
            legal = 0;
        end
        w = v[31:0];
    endfunction

    function automatic void m_write(input logic [31:0] d);
        wr_t e;
        e.addr = m_ptr; e.data = d;
        exp_q.push_back(e);
        m_count++;
        m_fresh = 0;
        if (m_ptr == DEPTH - 1) m_full = 1;
        else m_ptr++;
    endfunction

    // Reference model: advances once per clock edge from the driven inputs
    always @(posedge clk) begin
        logic [31:0] w;
        bit legal, li;
        m_hs = 0;
        if (rst) begin
            m_ptr = 0; m_count = 0; m_full = 0; m_err = 0; m_li_pend = 0; m_fresh = 1;
        end else if (start) begin
            m_ptr = 0; m_count = 0; m_full = 0; m_err = 0; m_li_pend = 0;
        end else if (m_li_pend) begin
            m_li_pend = 0;
            m_write(32'(longint'('h0D) * 2**26 + m_li_rt * 2**21 + m_li_rt * 2**16 + m_li_lo));
        end else if (in_valid && !m_full) begin
            m_hs = 1;
            model_enc(int'(in_op), int'(in_rs), int'(in_rt), int'(in_rd),
                      longint'(in_imm), longint'(in_target), w, legal, li);
            if (!legal) m_err = 1;
            else if (li) begin
                if (!LI_EN || m_ptr == DEPTH - 1) m_err = 1;
                else begin
                    m_write(w);
                    m_li_pend = 1;
                    m_li_rt = int'(in_rt);
                    m_li_lo = longint'(in_imm[15:0]);
                end
            end else m_write(w);
        end
    end

    // Monitor: compare status each cycle and pop expected writes
    always @(negedge clk) begin
        if (mon_en) begin
            wr_t e;
            chk("in_ready", 64'(in_ready), 64'(!start && !m_full && !m_li_pend));
            chk("word_count", 64'(word_count), 64'(m_count));
            chk("full", 64'(full), 64'(m_full));
            chk("err_illegal", 64'(err_illegal), 64'(m_err));
            if (imem_we) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", 64'(imem_we), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("imem_addr", 64'(imem_addr), 64'(e.addr));
                    chk("imem_wdata", 64'(imem_wdata), 64'(e.data));
                end
            end else begin
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("missing_write", 64'(imem_we), 64'd1);
                end
                if (m_fresh) begin
                    chk("reset_addr", 64'(imem_addr), 64'd0);
                    chk("reset_wdata", 64'(imem_wdata), 64'd0);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_req(input int op, input int rs, input int rt, input int rd,
                           input logic [31:0] imm, input logic [25:0] tgt);
        in_op = 5'(op); in_rs = 5'(rs); in_rt = 5'(rt); in_rd = 5'(rd);
        in_imm = imm; in_target = tgt;
        in_valid = 1'b1;
    endtask

    task automatic wait_hs(input string name);
        for (int n = 0; n < 30; n++) begin
            tick();
            if (m_hs) begin
                in_valid = 1'b0;
                return;
            end
        end
        n_checks++;
        n_errors++;
        $display("FAIL %s: handshake seen 0, required 1 within 30 cycles", name);
        in_valid = 1'b0;
    endtask

    task automatic send(input string name, input int op, input int rs, input int rt,
                        input int rd, input logic [31:0] imm, input logic [25:0] tgt);
        set_req(op, rs, rt, rd, imm, tgt);
        wait_hs(name);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        tick();
        mon_en = 1'b1;
        tick();
        rst = 1'b0;

        // ADD after reset, then idle
        send("add", 0, 1, 2, 3, 32'd0, 26'd0);
        repeat (2) tick();

        // Back-to-back LW, SW, J
        pulse_start();
        send("lw", 7, 29, 8, 0, 32'd4, 26'd0);
        send("sw", 8, 29, 8, 0, 32'd4, 26'd0);
        send("j", 11, 0, 0, 0, 32'd0, 26'h40);
        tick();

        // SRL ignoring rs, illegal op, then address unchanged
        pulse_start();
        send("srl", 5, 7, 5, 4, 32'd2, 26'd0);
        send("illegal", 31, 1, 1, 1, 32'd0, 26'd0);
        send("addi_after_illegal", 12, 3, 4, 0, 32'h0000_FFFF, 26'd0);
        tick();

        // Fill memory; held fifth request stalls until start
        pulse_start();
        for (int i = 0; i < DEPTH; i++) send("fill", 12, i, i + 1, 0, 32'(i * 3), 26'd0);
        set_req(12, 9, 9, 0, 32'h1234, 26'd0);
        repeat (3) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_hs("after_full_start");
        tick();

        // start with in_valid in the same cycle
        set_req(1, 2, 3, 4, 32'd0, 26'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_hs("start_with_valid");
        tick();

        // LI, LI with one slot left, reset during the second LI word
        pulse_start();
        send("li", 18, 0, 9, 0, 32'h1234_5678, 26'd0);
        repeat (2) tick();
        pulse_start();
        for (int i = 0; i < DEPTH - 1; i++) send("prefill", 14, 1, 2, 0, 32'(i), 26'd0);
        send("li_last", 18, 0, 9, 0, 32'hDEAD_BEEF, 26'd0);
        tick();
        pulse_start();
        send("li_rst", 18, 0, 3, 0, 32'hCAFE_0001, 26'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (2) tick();

        // Randomized traffic including start, reset and illegal ops
        for (int c = 0; c < 600; c++) begin
            int op;
            op = ($urandom_range(0, 9) == 0) ? $urandom_range(19, 31) : $urandom_range(0, 18);
            in_op = 5'(op);
            in_rs = 5'($urandom); in_rt = 5'($urandom); in_rd = 5'($urandom);
            in_imm = $urandom; in_target = 26'($urandom);
            in_valid = ($urandom_range(0, 9) < 7);
            start = ($urandom_range(0, 7) == 0);
            rst = ($urandom_range(0, 49) == 0);
            tick();
        end
        in_valid = 1'b0; start = 1'b0; rst = 1'b0;
        repeat (4) tick();
        chk("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
